// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor
// Description : Multi-channel coin front end. Each raw coin button is
//               synchronised, debounced and edge-detected; presses are queued
//               in a one-deep pending slot per channel and delivered one at a
//               time to the credit logic over valid/ready, round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor #(
    parameter int                           NUM_COINS       = 3,
    parameter int                           VALUE_W         = 8,
    parameter logic [NUM_COINS*VALUE_W-1:0] COIN_VALUES     = {8'd5, 8'd2, 8'd1},
    parameter int                           DEBOUNCE_CYCLES = 4,
    parameter int                           CH_W            = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_COINS-1:0] btn_coin,
    input  logic                 accept_en,
    output logic                 coin_valid,
    input  logic                 coin_ready,
    output logic [VALUE_W-1:0]   coin_value,
    output logic [CH_W-1:0]      coin_chan,
    output logic [NUM_COINS-1:0] pending,
    output logic                 reject_pulse,
    output logic                 overflow_pulse
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int                 c_cnt_w    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [NUM_COINS-1:0]   w_press;
    logic [NUM_COINS-1:0]   r_pending;
    logic [CH_W-1:0]        r_ptr;
    logic                   r_valid;
    logic [VALUE_W-1:0]     r_value;
    logic [CH_W-1:0]        r_chan;
    logic                   r_reject;
    logic                   r_overflow;

    logic [CH_W:0]          w_base;
    logic [2*NUM_COINS-1:0] w_search;
    logic [NUM_COINS-1:0]   w_rot;
    logic                   w_found;
    logic [CH_W-1:0]        w_grant_idx;
    logic [NUM_COINS-1:0]   w_grant_oh;
    logic [VALUE_W-1:0]     w_grant_value;
    logic                   w_load;
    logic [NUM_COINS-1:0]   w_clear;
    logic [NUM_COINS-1:0]   w_accepted;
    logic [NUM_COINS-1:0]   w_drop;

    // Per-channel synchroniser, debouncer and rising-edge (press) detector.
    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_chan
        logic               r_meta;
        logic               r_sync;
        logic               r_stable;
        logic [c_cnt_w-1:0] r_cnt;

        // Two-flop sync, then accept a level only after it differs from the
        // stable level for DEBOUNCE_CYCLES consecutive cycles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_meta   <= 1'b0;
                r_sync   <= 1'b0;
                r_stable <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_meta <= btn_coin[gi];
                r_sync <= r_meta;
                if (r_sync == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_stable <= r_sync;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end

        // A press is the edge on which stable is about to go 0->1.
        assign w_press[gi] = r_sync & ~r_stable & (r_cnt == c_cnt_last);
    end

    // Rotate the pending vector so bit 0 is the channel right after the pointer.
    assign w_base   = {1'b0, r_ptr} + (CH_W + 1)'(1);
    assign w_search = {r_pending, r_pending} >> w_base;
    assign w_rot    = w_search[NUM_COINS-1:0];

    // Round-robin search: first pending channel after the pointer, wrapping.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found     = 1'b1;
                w_grant_idx = CH_W'((int'(r_ptr) + 1 + k) % NUM_COINS);
            end
        end
    end

    // Decode the granted index into a one-hot clear mask and its coin value.
    always_comb begin
        w_grant_oh    = '0;
        w_grant_value = '0;
        for (int j = 0; j < NUM_COINS; j++) begin
            if (w_grant_idx == CH_W'(j)) begin
                w_grant_oh[j] = 1'b1;
                w_grant_value = COIN_VALUES[j*VALUE_W +: VALUE_W];
            end
        end
    end

    assign w_load     = (~r_valid | coin_ready) & w_found;
    assign w_clear    = w_load ? w_grant_oh : '0;
    assign w_accepted = accept_en ? w_press : '0;
    // A slot freed by a grant on this very edge can take the new press.
    assign w_drop     = w_accepted & r_pending & ~w_clear;

    // Pending slots plus the one-cycle reject/overflow indications.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_reject   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_clear) | w_accepted;
            r_reject   <= ~accept_en & (|w_press);
            r_overflow <= |w_drop;
        end
    end

    // Registered output slot and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_value <= '0;
            r_chan  <= '0;
            r_ptr   <= CH_W'(NUM_COINS - 1);
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_value <= w_grant_value;
            r_chan  <= w_grant_idx;
            r_ptr   <= w_grant_idx;
        end else if (r_valid && coin_ready) begin
            r_valid <= 1'b0;
            r_value <= '0;
            r_chan  <= '0;
        end
    end

    assign coin_valid     = r_valid;
    assign coin_value     = r_value;
    assign coin_chan      = r_chan;
    assign pending        = r_pending;
    assign reject_pulse   = r_reject;
    assign overflow_pulse = r_overflow;

endmodule
`default_nettype wire
